hex_display_mux: RTL and testbench

Parametrised multi-digit, time-multiplexed hexadecimal 7-segment display driver. It is the successor to the single-digit registered hex decoder.
- Accepts a packed word of DIGITS nibbles through a valid/ready load port.
- Holds the word in a pending buffer and swaps it into the display register only at a frame boundary, so a frame never shows a mix of old and new digits.
- Scans the digits onto one shared segment bus with per-digit anode enables, a guard band against ghosting, a per-digit decimal point and per-digit blanking.
- Sits between board-level status logic and the display pins.

---
 rtl/hex_display_pkg.sv | 18 +
 rtl/hex_seg_encode.sv | 12 +
 rtl/hex_display_mux.sv | 149 ++++++++++++++
 tb/tb_hex_display_mux.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for the multiplexed hex display: segment table, blank pattern
// and the parameter legality check used by hex_display_mux.
package hex_display_pkg;

  // Active-high {g,f,e,d,c,b,a}; entry n is the glyph for nibble n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic bit params_ok(input int digits, input int scan_div, input int guard);
    return (digits >= 1) && (digits <= 8) && (scan_div >= 2) &&
           (guard >= 0) && (scan_div > guard);
  endfunction

endpackage

// File: rtl/hex_seg_encode.sv
// Combinational nibble-to-7-segment encoder (active-high, gfedcba) with blanking.
module hex_seg_encode
  import hex_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  assign o_seg = i_blank ? SEG_OFF : SEG_HEX[i_nibble];

endmodule

// File: rtl/hex_display_mux.sv
// Time-multiplexed DIGITS-digit hex display driver with frame-aligned word updates.
// Build option: define HEX_DISPLAY_LZB_EN to enable leading-zero blanking.
module hex_display_mux
  import hex_display_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic [DIGITS-1:0]     load_blank,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_done
);

  if (!params_ok(DIGITS, SCAN_DIV, GUARD)) begin : g_bad_params
    $error("hex_display_mux: illegal DIGITS/SCAN_DIV/GUARD combination");
  end

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W   = $clog2(SCAN_DIV);
  localparam bit SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam bit AN_INV  = (AN_ACTIVE_LOW != 0);

  logic [CNT_W-1:0]    r_div_cnt;
  logic [IDX_W-1:0]    r_digit_idx;
  logic [4*DIGITS-1:0] r_disp_data, r_pend_data;
  logic [DIGITS-1:0]   r_disp_dp, r_pend_dp;
  logic [DIGITS-1:0]   r_disp_blank, r_pend_blank;
  logic                r_pend_valid;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;

  logic                w_slot_end, w_boundary, w_accept;
  logic [3:0]          w_nibble;
  logic                w_dp_sel, w_blank_sel;
  logic [DIGITS-1:0]   w_lzb, w_blank_all, w_an_sel;
  logic [6:0]          w_seg;

  assign w_slot_end = (r_div_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_boundary = w_slot_end && (r_digit_idx == IDX_W'(DIGITS - 1));
  assign load_ready = !r_pend_valid && !rst;
  assign w_accept   = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt   <= '0;
      r_digit_idx <= '0;
    end else if (w_slot_end) begin
      r_div_cnt   <= '0;
      r_digit_idx <= (r_digit_idx == IDX_W'(DIGITS - 1)) ? '0 : r_digit_idx + 1'b1;
    end else begin
      r_div_cnt   <= r_div_cnt + 1'b1;
    end
  end

  // The swap only happens with pending full, when load_ready is low, so the
  // capture below can never collide with it in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp_data  <= '0;
      r_disp_dp    <= '0;
      r_disp_blank <= '0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_boundary && r_pend_valid) begin
        r_disp_data  <= r_pend_data;
        r_disp_dp    <= r_pend_dp;
        r_disp_blank <= r_pend_blank;
        r_pend_valid <= 1'b0;
      end
      if (w_accept) begin
        r_pend_data  <= load_data;
        r_pend_dp    <= load_dp;
        r_pend_blank <= load_blank;
        r_pend_valid <= 1'b1;
      end
    end
  end

`ifdef HEX_DISPLAY_LZB_EN
  always_comb begin
    logic leading;
    w_lzb   = '0;
    leading = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      leading  = leading && (r_disp_data[4*d +: 4] == 4'h0);
      w_lzb[d] = leading;
    end
  end
`else
  assign w_lzb = '0;
`endif

  assign w_blank_all = r_disp_blank | w_lzb;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_nibble    = '0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_digit_idx == IDX_W'(d)) begin
        w_nibble    = r_disp_data[4*d +: 4];
        w_dp_sel    = r_disp_dp[d];
        w_blank_sel = w_blank_all[d];
      end
    end
  end

  hex_seg_encode u_seg_encode (
    .i_nibble (w_nibble),
    .i_blank  (w_blank_sel),
    .o_seg    (w_seg)
  );

  assign w_an_sel = (r_div_cnt >= CNT_W'(GUARD)) ? (DIGITS'(1) << r_digit_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= SEG_OFF ^ {7{SEG_INV}};
      r_dp  <= SEG_INV;
      r_an  <= {DIGITS{AN_INV}};
    end else begin
      r_seg <= w_seg ^ {7{SEG_INV}};
      r_dp  <= w_dp_sel ^ SEG_INV;
      r_an  <= w_an_sel ^ {DIGITS{AN_INV}};
    end
  end

  assign seg_out    = r_seg;
  assign dp_out     = r_dp;
  assign an_out     = r_an;
  assign frame_done = w_boundary;

endmodule

// File: tb/tb_hex_display_mux.sv
// Scoreboard bench for hex_display_mux (DIGITS=4, SCAN_DIV=4, GUARD=1, active-low).
module tb_hex_display_mux;

  localparam int D = 4;
  localparam int S = 4;
  localparam int G = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [15:0]   load_data = '0;
  logic [3:0]    load_dp = '0;
  logic [3:0]    load_blank = '0;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic [3:0]    an_out;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  hex_display_mux #(
    .DIGITS(D), .SCAN_DIV(S), .GUARD(G), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .load_blank (load_blank),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
    logic       pend_v;
  } exp_t;

  exp_t sb[$];

  logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Digits above the most significant nonzero nibble are dark when blanking is built in.
  function automatic logic [3:0] lzb_mask(input logic [15:0] w);
`ifdef HEX_DISPLAY_LZB_EN
    logic [3:0] m;
    int hi;
    m  = '0;
    hi = 0;
    for (int d = 0; d < D; d++) if (w[4*d +: 4] != 4'h0) hi = d;
    for (int d = 0; d < D; d++) if (d > hi) m[d] = 1'b1;
    return m;
`else
    return w[3:0] & 4'h0;
`endif
  endfunction

  // Reference model: position in the scan is just the cycle count since reset.
  int          m_t = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  logic [3:0]  m_disp_dp = '0, m_pend_dp = '0, m_disp_bl = '0, m_pend_bl = '0;
  logic        m_pend_v = 1'b0;

  always @(posedge clk) begin : model
    exp_t e;
    int slot, phase;
    logic [3:0] dark;
    if (rst) begin
      e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF; e.fd = 1'b0; e.pend_v = 1'b0;
      m_t = 0; m_disp = '0; m_pend = '0; m_disp_dp = '0; m_pend_dp = '0;
      m_disp_bl = '0; m_pend_bl = '0; m_pend_v = 1'b0;
    end else begin
      slot  = (m_t / S) % D;
      phase = m_t % S;
      dark  = m_disp_bl | lzb_mask(m_disp);
      e.seg = dark[slot] ? 7'h7F : ~seg_ref[m_disp[4*slot +: 4]];
      e.dp  = ~m_disp_dp[slot];
      e.an  = (phase >= G) ? ~(4'b0001 << slot) : 4'hF;
      if (phase == S - 1 && slot == D - 1 && m_pend_v) begin
        m_disp = m_pend; m_disp_dp = m_pend_dp; m_disp_bl = m_pend_bl; m_pend_v = 1'b0;
      end else if (load_valid && !m_pend_v) begin
        m_pend = load_data; m_pend_dp = load_dp; m_pend_bl = load_blank; m_pend_v = 1'b1;
      end
      m_t++;
      e.fd     = ((m_t % S) == S - 1) && (((m_t / S) % D) == D - 1);
      e.pend_v = m_pend_v;
    end
    sb.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("seg_out", 32'(seg_out), 32'(e.seg));
      check("dp_out", 32'(dp_out), 32'(e.dp));
      check("an_out", 32'(an_out), 32'(e.an));
      check("frame_done", 32'(frame_done), 32'(e.fd));
      check("load_ready", 32'(load_ready), 32'(!e.pend_v && !rst));
    end
  end

  task automatic do_load(input logic [15:0] w, input logic [3:0] dp, input logic [3:0] bl);
    bit done = 0;
    load_valid = 1'b1; load_data = w; load_dp = dp; load_blank = bl;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (load_ready) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL load_timeout: load_ready never rose for word %0h", w);
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic load_at_boundary(input logic [15:0] w);
    bit done = 0;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (frame_done) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL frame_timeout: no frame_done within budget");
    end
    load_valid = 1'b1; load_data = w; load_dp = '0; load_blank = '0;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    do_load(16'h1234, 4'b0000, 4'b0000);
    idle(2 * S * D);
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    do_load(16'h5555, 4'b0000, 4'b0000);
    idle(3 * S * D);
    load_at_boundary(16'hBEEF);
    idle(3 * S * D);
    do_load(16'h8888, 4'b0001, 4'b0100);
    idle(2 * S * D);
    do_load(16'h0050, 4'b0000, 4'b0000);
    idle(2 * S * D);
    do_load(16'h0000, 4'b0000, 4'b0000);
    idle(2 * S * D);
    // Reset while a word is waiting in pending.
    do_load(16'hC0DE, 4'b1010, 4'b0000);
    idle(5);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2 * S * D);
    for (int i = 0; i < 24; i++) begin
      logic [15:0] w;
      w = 16'($urandom) & (($urandom_range(0, 1) == 1) ? 16'h00FF : 16'hFFFF);
      do_load(w, 4'($urandom), 4'($urandom) & 4'($urandom));
      idle(int'($urandom_range(0, 20)));
    end
    idle(2 * S * D);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
